// File: rtl/myproject_sdiv_22s_9ns_15_seq.sv
// Sequential restoring divider: 22-bit signed dividend by 9-bit unsigned divisor.
// Produces one quotient bit per clock, then a saturated 15-bit quotient and a signed remainder.
module myproject_sdiv_22s_9ns_15_seq #(
   parameter int din0_WIDTH = 22,
   parameter int din1_WIDTH = 9,
   parameter int dout_WIDTH = 15
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_idle,
   output logic                  ap_done,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH:0]   rem,
   output logic                  ovf,
   output logic                  dbz
);

   localparam int CW = $clog2(din0_WIDTH);
   localparam int RW = din1_WIDTH + 1;
   localparam logic [din0_WIDTH-1:0] POS_LIM  = din0_WIDTH'((1 << (dout_WIDTH - 1)) - 1);
   localparam logic [din0_WIDTH-1:0] NEG_LIM  = din0_WIDTH'(1 << (dout_WIDTH - 1));
   localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state, state_nxt;
   logic                    sign;
   logic [din0_WIDTH-1:0]   mag;   // dividend bits shift out the top, quotient bits shift in the bottom
   logic [din1_WIDTH-1:0]   div;
   logic [RW-1:0]           r;
   logic [CW-1:0]           cnt;

   logic [din0_WIDTH:0]     din0_ext;
   logic [din0_WIDTH:0]     din0_abs;
   logic [RW-1:0]           r_sh;
   logic [RW-1:0]           r_step;
   logic                    q_bit;
   logic [din0_WIDTH-1:0]   q_mag;
   logic [dout_WIDTH-1:0]   dout_fin;
   logic [RW-1:0]           rem_fin;
   logic                    ovf_fin;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ap_start) state_nxt = CALC;
         CALC:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ap_idle = (state == IDLE);
   assign ap_done = (state == DONE);

   // Magnitude in one extra bit so that the most negative dividend is exact.
   assign din0_ext = {din0[din0_WIDTH-1], din0};
   assign din0_abs = din0[din0_WIDTH-1] ? (~din0_ext + 1'b1) : din0_ext;

   always_comb begin
      r_sh   = {r[RW-2:0], mag[din0_WIDTH-1]};
      q_bit  = (r_sh >= {1'b0, div});
      r_step = q_bit ? (r_sh - {1'b0, div}) : r_sh;
      q_mag  = {mag[din0_WIDTH-2:0], q_bit};
   end

   // Final result from the last step, so outputs are valid during the DONE cycle.
   always_comb begin
      dout_fin = q_mag[dout_WIDTH-1:0];
      ovf_fin  = 1'b0;
      rem_fin  = sign ? (RW'(0) - r_step) : r_step;
      if (div == '0) begin
         dout_fin = sign ? DOUT_MIN : DOUT_MAX;
         ovf_fin  = 1'b1;
         rem_fin  = '0;
      end else if (!sign) begin
         if (q_mag > POS_LIM) begin
            dout_fin = DOUT_MAX;
            ovf_fin  = 1'b1;
         end
      end else begin
         if (q_mag > NEG_LIM) begin
            dout_fin = DOUT_MIN;
            ovf_fin  = 1'b1;
         end else begin
            dout_fin = dout_WIDTH'(0) - q_mag[dout_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sign <= 1'b0;
         mag  <= '0;
         div  <= '0;
         r    <= '0;
         cnt  <= '0;
         dout <= '0;
         rem  <= '0;
         ovf  <= 1'b0;
         dbz  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (ap_start) begin
               sign <= din0[din0_WIDTH-1];
               mag  <= din0_abs[din0_WIDTH-1:0];
               div  <= din1;
               r    <= '0;
               cnt  <= CW'(din0_WIDTH - 1);
            end
            CALC: begin
               mag <= q_mag;
               r   <= r_step;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  dout <= dout_fin;
                  rem  <= rem_fin;
                  ovf  <= ovf_fin;
                  dbz  <= (div == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/myproject_sdiv_22s_9ns_15_seq.md
# myproject_sdiv_22s_9ns_15_seq

Sequential signed-by-unsigned divider: the inverse of the 15s×9ns→22 product path. It divides a 22-bit signed dividend by a 9-bit unsigned divisor with C truncating semantics. It produces a saturated 15-bit signed quotient and a signed remainder, using one quotient bit per clock and an ap_start/ap_done block-level handshake. It sits after a product/accumulate stage and rescales accumulated values by a runtime divisor, e.g. normalization by count.

## Interface
- din0_WIDTH, 22, dividend width (signed)
- din1_WIDTH, 9, divisor width (unsigned)
- dout_WIDTH, 15, quotient width (signed, saturated)
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_start  in  1  request; sampled only while ap_idle=1
- ap_idle  out  1  ready to accept a new operation
- ap_done  out  1  one-cycle pulse, results valid
- din0  in  din0_WIDTH  dividend, two's complement
- din1  in  din1_WIDTH  divisor, unsigned
- dout  out  dout_WIDTH  quotient, saturated
- rem  out  din1_WIDTH+1  remainder, signed; sign follows the dividend
- ovf  out  1  quotient saturated (includes divide-by-zero)
- dbz  out  1  divisor was zero

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- **IDLE:** ap_idle=1. When ap_start=1, the block registers the following, then goes to CALC:
  - sign = din0 MSB
  - |din0| into a 22-bit unsigned magnitude register, computed in 23 bits so −2^21 is exact
  - din1
  - iteration counter = din0_WIDTH−1
- **CALC:** one restoring step per cycle, MSB first.
  - Partial remainder r (din1_WIDTH+1 bits) = {r, next dividend bit}.
  - If r ≥ divisor: r −= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter decrements each step. After the step with counter=0, go to DONE.
- **Divisor zero:** CALC still runs its full length, with the same latency. The result is forced in DONE: dout=+16383 if sign=0, −16384 if sign=1; rem=0; ovf=1; dbz=1.
- **DONE:**
  - Output registers load, and ap_done=1 for exactly this cycle. Next state is IDLE.
  - The unsigned quotient magnitude is 22 bits. It is negated if sign=1.
  - If the signed result is outside [−16384, 16383], dout is clamped to the bound and ovf=1; otherwise ovf=0.
  - rem = r, negated if sign=1.
- ap_start is ignored in CALC and DONE. There is no queueing.
- Inputs may change freely after the accept cycle.
- dout, rem, ovf and dbz hold their values until the next DONE.
- **Reset:**
  - Reset asserted at any time (including mid-CALC) immediately forces IDLE.
  - All outputs reset to: ap_idle=1, ap_done=0, dout=0, rem=0, ovf=0, dbz=0.
  - The in-flight operation is discarded, with no ap_done.

## Timing
- Accept edge is E0 (ap_start=1 and ap_idle=1).
- ap_idle falls in the cycle after E0.
- CALC occupies 22 cycles.
- ap_done=1 and results are valid in cycle 23 after E0. ap_idle=1 again in cycle 24.
- Minimum start-to-start interval is 24 cycles. A start held high continuously is accepted on the first cycle after DONE.
- Latency is fixed regardless of operands, including divisor 0 and saturation.

## Test plan
- **Basic signs:**
  - din0=1000, din1=7 → 23 cycles later ap_done: dout=142, rem=6, ovf=0, dbz=0.
  - din0=−1000, din1=7 → dout=−142, rem=−6.
  - din0=−1050, din1=7 → dout=−150, rem=0.
- **Saturation:**
  - din0=2097151, din1=1 → dout=16383, ovf=1, rem=0.
  - din0=−2097152, din1=3 → dout=−16384, ovf=1, rem=−2.
  - din0=−16384, din1=1 → dout=−16384, ovf=0.
- **Divide by zero:**
  - din0=500, din1=0 → dout=16383, rem=0, ovf=1, dbz=1, latency still 23.
  - din0=−5, din1=0 → dout=−16384.
- **Handshake:**
  - ap_start held high for 60 cycles with din0=100, din1=10 → accepts at cycles 0, 24 and 48; ap_done pulses at cycles 23 and 47, one cycle each; dout=10.
  - Operand changes mid-CALC do not affect the result.
- **Reset mid-op:** assert ap_rst_n=0 asynchronously at CALC cycle 10 → ap_idle=1 and all outputs 0 immediately, no ap_done. After release, a new start din0=9, din1=4 → dout=2, rem=1.
- **Random sweep:** 10k random din0 and din1≠0 against a truncating-division model with clamping. rem satisfies din0 = q_unsat·din1 + rem and |rem| < din1.
